// File: rtl/lbike_pkg.sv
`default_nettype none
// ============================================================================
//  Package     : lbike_pkg
//  Description : Shared constants for the lightbike input path. Holds the
//                direction codes, the PS/2 set-2 scan codes used by the game,
//                the decoder state encoding and the direction-turn rule.
//  Revision    : 1.0 - initial release
// ============================================================================
package lbike_pkg;

    // Direction encoding. Opposite directions differ only in bit 1.
    localparam logic [1:0] DIR_UP    = 2'd0;
    localparam logic [1:0] DIR_RIGHT = 2'd1;
    localparam logic [1:0] DIR_DOWN  = 2'd2;
    localparam logic [1:0] DIR_LEFT  = 2'd3;

    // Player 1 keys (plain codes)
    localparam logic [7:0] SC_W     = 8'h1D;
    localparam logic [7:0] SC_S     = 8'h1B;
    localparam logic [7:0] SC_A     = 8'h1C;
    localparam logic [7:0] SC_D     = 8'h23;
    // Player 2 keys (valid only after the E0 prefix)
    localparam logic [7:0] SC_UP    = 8'h75;
    localparam logic [7:0] SC_DOWN  = 8'h72;
    localparam logic [7:0] SC_LEFT  = 8'h6B;
    localparam logic [7:0] SC_RIGHT = 8'h74;
    // Control keys
    localparam logic [7:0] SC_SPACE = 8'h29;
    localparam logic [7:0] SC_ESC   = 8'h76;
    // Prefixes
    localparam logic [7:0] SC_EXT   = 8'hE0;
    localparam logic [7:0] SC_BRK   = 8'hF0;

    // Scan-code decoder states
    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_EXT     = 2'd1,
        ST_BRK     = 2'd2,
        ST_EXT_BRK = 2'd3
    } dec_state_t;

    // A bike may not turn back onto itself: a reversal request keeps the
    // current heading, anything else (including the same heading) is taken.
    function automatic logic [1:0] dir_turn(input logic [1:0] cur,
                                            input logic [1:0] req);
        return (req == (cur ^ 2'b10)) ? cur : req;
    endfunction

endpackage
`default_nettype wire

// File: rtl/ps2_rx.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_rx
//  Description : PS/2 device-to-host frame receiver in the board_clk domain.
//                Synchronises the raw PS/2 lines, detects falling clock edges,
//                shifts in 11-bit frames and checks start/parity/stop.
//                A watchdog drops a partial frame after TIMEOUT_CYCLES idle.
//  Ports       : board_clk, reset (async, active-high)
//                i_ps2_clk, i_ps2_dat : raw asynchronous PS/2 lines
//                o_byte_valid         : 1-cycle strobe, good frame received
//                o_byte               : last good data byte (held)
//                o_frame_err          : 1-cycle strobe, bad frame or timeout
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_rx #(
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int SYNC_STAGES    = 2      // minimum 2
) (
    input  logic       board_clk,
    input  logic       reset,
    input  logic       i_ps2_clk,
    input  logic       i_ps2_dat,
    output logic       o_byte_valid,
    output logic [7:0] o_byte,
    output logic       o_frame_err
);

    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);

    logic [SYNC_STAGES-1:0] r_clk_sync;
    logic [SYNC_STAGES-1:0] r_dat_sync;
    logic                   r_clk_prev;
    logic [10:0]            r_shift;
    logic [3:0]             r_bitcnt;
    logic [WD_W-1:0]        r_wdog;

    logic        w_clk_s;
    logic        w_dat_s;
    logic        w_fall;
    logic [10:0] w_frame;
    logic        w_good;

    // Idle PS/2 lines are high, so synchronisers reset to 1 to avoid a
    // phantom falling edge straight out of reset.
    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) begin
            r_clk_sync <= '1;
            r_dat_sync <= '1;
        end else begin
            r_clk_sync <= {r_clk_sync[SYNC_STAGES-2:0], i_ps2_clk};
            r_dat_sync <= {r_dat_sync[SYNC_STAGES-2:0], i_ps2_dat};
        end
    end

    assign w_clk_s = r_clk_sync[SYNC_STAGES-1];
    assign w_dat_s = r_dat_sync[SYNC_STAGES-1];
    assign w_fall  = r_clk_prev & ~w_clk_s;

    // Bits arrive LSB first, so shifting right leaves the start bit in [0]
    // and the stop bit in [10] once the 11th bit is in.
    assign w_frame = {w_dat_s, r_shift[10:1]};
    assign w_good  = ~w_frame[0] & w_frame[10] & (^w_frame[9:1]);

    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) begin
            r_clk_prev   <= 1'b1;
            r_shift      <= '0;
            r_bitcnt     <= '0;
            r_wdog       <= '0;
            o_byte_valid <= 1'b0;
            o_byte       <= '0;
            o_frame_err  <= 1'b0;
        end else begin
            r_clk_prev   <= w_clk_s;
            o_byte_valid <= 1'b0;
            o_frame_err  <= 1'b0;
            if (w_fall) begin
                r_wdog  <= '0;
                r_shift <= w_frame;
                if (r_bitcnt == 4'd10) begin
                    r_bitcnt <= '0;
                    if (w_good) begin
                        o_byte_valid <= 1'b1;
                        o_byte       <= w_frame[8:1];
                    end else begin
                        o_frame_err  <= 1'b1;
                    end
                end else begin
                    r_bitcnt <= r_bitcnt + 4'd1;
                end
            end else if (r_bitcnt != 4'd0) begin
                // Watchdog only runs while a frame is partially received.
                if (r_wdog == WD_W'(TIMEOUT_CYCLES - 1)) begin
                    r_bitcnt    <= '0;
                    r_wdog      <= '0;
                    o_frame_err <= 1'b1;
                end else begin
                    r_wdog <= r_wdog + WD_W'(1);
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: rtl/ps2_game_input.sv
`default_nettype none
// ============================================================================
//  Module      : ps2_game_input
//  Description : Lightbike keyboard front end. Receives PS/2 bytes, decodes
//                the E0/F0 prefixes and turns key makes into registered
//                player directions and one-cycle start/escape pulses.
//  Ports       : board_clk, reset (async, active-high)
//                ps2_clk, ps2_dat : raw PS/2 lines
//                load_dirs        : force default directions (wins over keys)
//                p1_dir, p2_dir   : UP=0 RIGHT=1 DOWN=2 LEFT=3
//                start_pulse      : space make; esc_pulse : escape make
//                scan_code        : last good byte; frame_err : rx error
//  Revision    : 1.0 - initial release
// ============================================================================
module ps2_game_input
    import lbike_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100000,
    parameter int SYNC_STAGES    = 2
) (
    input  logic       board_clk,
    input  logic       reset,
    input  logic       ps2_clk,
    input  logic       ps2_dat,
    input  logic       load_dirs,
    output logic [1:0] p1_dir,
    output logic [1:0] p2_dir,
    output logic       start_pulse,
    output logic       esc_pulse,
    output logic [7:0] scan_code,
    output logic       frame_err
);

    logic       w_byte_valid;
    logic [7:0] w_byte;
    dec_state_t r_state;

    ps2_rx #(
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES),
        .SYNC_STAGES    (SYNC_STAGES)
    ) u_rx (
        .board_clk    (board_clk),
        .reset        (reset),
        .i_ps2_clk    (ps2_clk),
        .i_ps2_dat    (ps2_dat),
        .o_byte_valid (w_byte_valid),
        .o_byte       (w_byte),
        .o_frame_err  (frame_err)
    );

    assign scan_code = w_byte;

    always_ff @(posedge board_clk or posedge reset) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            p1_dir      <= DIR_RIGHT;
            p2_dir      <= DIR_LEFT;
            start_pulse <= 1'b0;
            esc_pulse   <= 1'b0;
        end else begin
            start_pulse <= 1'b0;
            esc_pulse   <= 1'b0;
            if (w_byte_valid) begin
                case (r_state)
                    ST_IDLE: begin
                        if (w_byte == SC_EXT) begin
                            r_state <= ST_EXT;
                        end else if (w_byte == SC_BRK) begin
                            r_state <= ST_BRK;
                        end else begin
                            case (w_byte)
                                SC_W:     p1_dir <= dir_turn(p1_dir, DIR_UP);
                                SC_S:     p1_dir <= dir_turn(p1_dir, DIR_DOWN);
                                SC_A:     p1_dir <= dir_turn(p1_dir, DIR_LEFT);
                                SC_D:     p1_dir <= dir_turn(p1_dir, DIR_RIGHT);
                                SC_SPACE: start_pulse <= 1'b1;
                                SC_ESC:   esc_pulse   <= 1'b1;
                                default:  ;
                            endcase
                        end
                    end
                    ST_EXT: begin
                        // Repeated E0 keeps us waiting for the real key.
                        if (w_byte == SC_BRK) begin
                            r_state <= ST_EXT_BRK;
                        end else if (w_byte != SC_EXT) begin
                            r_state <= ST_IDLE;
                            case (w_byte)
                                SC_UP:    p2_dir <= dir_turn(p2_dir, DIR_UP);
                                SC_DOWN:  p2_dir <= dir_turn(p2_dir, DIR_DOWN);
                                SC_LEFT:  p2_dir <= dir_turn(p2_dir, DIR_LEFT);
                                SC_RIGHT: p2_dir <= dir_turn(p2_dir, DIR_RIGHT);
                                default:  ;
                            endcase
                        end
                    end
                    // Break codes: swallow the released key.
                    ST_BRK:     r_state <= ST_IDLE;
                    ST_EXT_BRK: r_state <= ST_IDLE;
                    default:    r_state <= ST_IDLE;
                endcase
            end
            // Placed last so it overrides any key action in the same cycle.
            if (load_dirs) begin
                p1_dir <= DIR_RIGHT;
                p2_dir <= DIR_LEFT;
            end
        end
    end

endmodule
`default_nettype wire

// File: doc/ps2_game_input.md
Name: ps2_game_input

Overview:
Upstream input stage for the lightbike game. It receives raw PS/2 keyboard frames, checks them, and decodes the E0 (extended) and F0 (break) prefixes. From the decoded keys it produces registered player directions and single-cycle start/escape pulses, all synchronous to board_clk. It replaces direct use of the scan_ready strobe as a clock and feeds p1_dir/p2_dir/start/reset into the game state machine.

Parameters:
TIMEOUT_CYCLES, 100000, board_clk cycles without a PS/2 falling edge before a partial frame is discarded (2 ms at 50 MHz)
SYNC_STAGES, 2, synchronizer depth on ps2_clk/ps2_dat

Ports:
board_clk  in  1  system clock
reset  in  1  asynchronous, active-high
ps2_clk  in  1  raw PS/2 clock, asynchronous
ps2_dat  in  1  raw PS/2 data, asynchronous
load_dirs  in  1  one-cycle strobe from game FSM (state I): force default directions
p1_dir  out  2  player 1 direction, UP=0 RIGHT=1 DOWN=2 LEFT=3
p2_dir  out  2  player 2 direction, same encoding
start_pulse  out  1  one-cycle pulse on space make (0x29)
esc_pulse  out  1  one-cycle pulse on escape make (0x76)
scan_code  out  8  last valid received byte, for SSD debug
frame_err  out  1  one-cycle pulse on bad frame or timeout

Behaviour:
- Reset: clock domain is board_clk; reset is asynchronous, active-high. Reset values: p1_dir=RIGHT(1), p2_dir=LEFT(3), start_pulse=0, esc_pulse=0, scan_code=0, frame_err=0, bit counter=0, decoder FSM=IDLE. Reset mid-frame discards the partial frame.
- Synchronizer: SYNC_STAGES flops on each PS/2 input. A falling edge is registered-prev=1 and sync=0, lasting one cycle.
- Receiver: samples ps2_dat on each falling edge into an 11-bit shift register. Frame order: start(0), d0..d7 LSB first, odd parity, stop(1). Bit counter runs 0..10.
- Frame complete (11th edge), good frame (start=0, stop=1, XOR of d0..d7 and parity = 1):
  - byte_valid for 1 cycle on the cycle after the edge;
  - scan_code updates on that same cycle.
- Frame complete, bad frame: frame_err pulses 1 cycle; no byte is produced.
- Timeout: while the counter is nonzero, a watchdog counts board_clk cycles and clears on every edge. At TIMEOUT_CYCLES: counter goes to 0 and frame_err pulses. The watchdog is idle while counter=0.
- Decoder FSM (advances only on byte_valid):
  - IDLE: E0→EXT; F0→BRK; other→plain make action, stay IDLE.
  - EXT: F0→EXT_BRK; E0→EXT; other→extended make action, →IDLE.
  - BRK: any→IDLE, no action (E0 also →IDLE).
  - EXT_BRK: any→IDLE, no action.
- Plain make actions:
  - 0x1D → p1 UP; 0x1B → p1 DOWN; 0x1C → p1 LEFT; 0x23 → p1 RIGHT.
  - 0x29 → start_pulse; 0x76 → esc_pulse.
  - All other codes: no action.
- Extended make actions: 0x75 → p2 UP; 0x72 → p2 DOWN; 0x6B → p2 LEFT; 0x74 → p2 RIGHT. Other codes: no action. Plain 0x75/0x72/0x6B/0x74 (keypad) must NOT move p2.
- Latency: action outputs update or pulse on the cycle after byte_valid, i.e. 2 board_clk cycles after the stop-bit falling edge is detected.
- Direction update rules:
  - A requested direction equal to current^2'b10 (reversal) is ignored.
  - The same direction produces no change.
  - Typematic repeat makes are harmless.
- load_dirs sets p1=RIGHT, p2=LEFT. It wins over a key action in the same cycle.
- start_pulse and esc_pulse never assert in the same cycle (one byte per action).

Decomposition:
- Shared package lbike_pkg holds:
  - direction codes DIR_UP/RIGHT/DOWN/LEFT;
  - scan-code constants SC_W, SC_S, SC_A, SC_D, SC_UP, SC_DOWN, SC_LEFT, SC_RIGHT, SC_SPACE, SC_ESC, SC_EXT(E0), SC_BRK(F0);
  - decoder state encodings.
- Sub-module ps2_rx contains the synchronizer, edge detect, shift/parity/stop check and watchdog. Its outputs are byte_valid, byte, frame_err. The top level contains the decoder FSM and direction registers.

Test Plan:
1. Reset, then frame 0x1D → p1_dir 1→0 two cycles after the stop edge; scan_code=0x1D; no pulses.
2. Frames E0,75 → p2_dir 3→0. Then plain frame 0x72 → p2_dir stays 0 (not extended).
3. After reset, frame 0x1C (LEFT, reversal of RIGHT) → p1_dir stays 1. Then 0x1B → p1_dir=2. Then F0,1D → p1_dir stays 2 (break ignored, FSM back to IDLE).
4. Frame 0x29 sent with parity bit flipped → frame_err pulses 1 cycle; start_pulse stays 0; scan_code unchanged. Then a good 0x29 → start_pulse high exactly 1 cycle.
5. Send 5 bits, then idle TIMEOUT_CYCLES → frame_err pulse, counter=0. Next full 0x76 → esc_pulse 1 cycle.
6. With p1=UP, assert load_dirs on the same cycle a 0x23 action lands → p1=RIGHT, p2=LEFT. Assert reset mid-frame → all outputs return to reset values, and the next full frame decodes correctly.
